dmem_responder: RTL and testbench

Single-port data memory responder that serves load/store requests issued by the `rv32i` core over a valid/ready request channel and returns results over a valid/ready response channel. It sits on the core's data bus and provides word-addressed storage mapped at `BASE_ADDR`. It applies a configurable wait-state delay and flags out-of-range and misaligned accesses. It holds one outstanding transaction at a time.

---
 rtl/dmem_responder.sv | 122 ++++++++++++
 tb/tb_dmem_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-port data memory responder on the core's valid/ready data bus.
// Serves one load or store at a time, with wait states and error reporting for bad addresses.
module dmem_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
   parameter int          WAIT_CYCLES = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] req_addr_i,
   input  logic        req_we_i,
   input  logic [31:0] req_wdata_i,
   input  logic [3:0]  req_be_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);
   // state  | meaning
   // S_IDLE | ready for a request; request fields captured on acceptance
   // S_WAIT | counting wait states; the access is performed on the exit edge
   // S_RESP | response held on rsp_* until the core takes it

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_next;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_we;
   logic [3:0]  r_be;
   logic [31:0] r_rdata;
   logic        r_err;
   logic [31:0] r_mem [DEPTH_WORDS];

   logic [32:0]   w_offset;
   logic          w_in_range;
   logic          w_err;
   logic [AW-1:0] w_index;
   logic          w_accept;
   logic          w_commit;

   assign w_offset   = {1'b0, r_addr} - {1'b0, BASE_ADDR};
   assign w_in_range = !w_offset[32] && (w_offset < (33'(DEPTH_WORDS) << 2));
   assign w_index    = w_offset[AW+1:2];
   assign w_err      = !w_in_range || (r_addr[1:0] != 2'b00);
   assign w_accept   = (r_state == S_IDLE) && req_valid_i;
   // The counter is allowed to run down to zero, so even WAIT_CYCLES=0 spends one cycle in S_WAIT.
   assign w_commit   = (r_state == S_WAIT) && (r_cnt == 4'd0);

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (req_valid_i) begin
               w_next     = S_WAIT;
               w_cnt_next = 4'(WAIT_CYCLES);
            end
         end
         S_WAIT: begin
            if (r_cnt == 4'd0) w_next = S_RESP;
            else               w_cnt_next = r_cnt - 4'd1;
         end
         S_RESP: begin
            if (rsp_ready_i) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_we    <= 1'b0;
         r_be    <= 4'd0;
         r_rdata <= 32'd0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         if (w_accept) begin
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
            r_we    <= req_we_i;
            r_be    <= req_be_i;
         end
         if (w_commit) begin
            r_err   <= w_err;
            r_rdata <= (w_err || r_we) ? 32'd0 : r_mem[w_index];
         end
      end
   end

   // Storage has no reset; a store is committed only on the edge that enters S_RESP.
   always_ff @(posedge clk_i) begin
      if (w_commit && r_we && !w_err) begin
         for (int k = 0; k < 4; k++) begin
            if (r_be[k]) r_mem[w_index][8*k +: 8] <= r_wdata[8*k +: 8];
         end
      end
   end

   assign req_ready_o = (r_state == S_IDLE);
   assign rsp_valid_o = (r_state == S_RESP);
   assign rsp_rdata_o = r_rdata;
   assign rsp_err_o   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_CYCLES = 1, 0, 15) driven with directed
// transactions and checked against an address-rule memory model every cycle.
module tb_dmem_responder;
   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst_n     [3];
   logic        req_valid [3];
   logic        req_ready [3];
   logic [31:0] req_addr  [3];
   logic        req_we    [3];
   logic [31:0] req_wdata [3];
   logic [3:0]  req_be    [3];
   logic        rsp_valid [3];
   logic        rsp_ready [3];
   logic [31:0] rsp_rdata [3];
   logic        rsp_err   [3];

   int vec  = 0;
   int errs = 0;
   int cyc  = 0;

   function automatic int wc(int i);
      return (i == 0) ? 1 : ((i == 1) ? 0 : 15);
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int WCG = (g == 0) ? 1 : ((g == 1) ? 0 : 15);
      dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WCG)) u_dut (
         .clk_i       (clk),
         .rst_ni      (rst_n[g]),
         .req_valid_i (req_valid[g]),
         .req_ready_o (req_ready[g]),
         .req_addr_i  (req_addr[g]),
         .req_we_i    (req_we[g]),
         .req_wdata_i (req_wdata[g]),
         .req_be_i    (req_be[g]),
         .rsp_valid_o (rsp_valid[g]),
         .rsp_ready_i (rsp_ready[g]),
         .rsp_rdata_o (rsp_rdata[g]),
         .rsp_err_o   (rsp_err[g])
      );
   end

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: word memory keyed by instance and word index, plus the address rules.
   logic [31:0] mdl [int];
   logic [31:0] exp_rdata [3];
   logic        exp_err   [3];
   bit          pending   [3];
   logic [31:0] last_rdata [3];
   logic        last_err   [3];
   int          last_lat   [3];

   task automatic mdl_txn(input int i, input logic [31:0] a, input logic we, input logic [31:0] wd,
                          input logic [3:0] be, output logic [31:0] rd, output logic er);
      longint la  = longint'({32'h0, a});
      longint lb  = longint'({32'h0, BASE});
      int     key;
      logic [31:0] w;
      er = (la < lb) || (la >= lb + 4 * DEPTH) || (a % 4 != 0);
      rd = 32'h0;
      if (!er) begin
         key = i * DEPTH + int'((la - lb) / 4);
         w   = mdl.exists(key) ? mdl[key] : 32'h0;
         if (we) begin
            for (int k = 0; k < 4; k++) if (be[k]) w[8*k +: 8] = wd[8*k +: 8];
            mdl[key] = w;
         end else begin
            rd = w;
         end
      end
   endtask

   // Compare process: every cycle of every instance out of reset.
   bit          prev_valid [3];
   int          acc_cyc    [3];
   logic [31:0] held_rdata [3];
   logic        held_err   [3];

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst_n[i]) begin
            prev_valid[i] = 1'b0;
         end else begin
            chk($sformatf("ready_valid_excl[%0d]", i), 32'(req_ready[i] & rsp_valid[i]), 32'h0);
            if (rsp_valid[i] && !prev_valid[i]) begin
               last_lat[i]   = cyc - acc_cyc[i];
               last_rdata[i] = rsp_rdata[i];
               last_err[i]   = rsp_err[i];
               held_rdata[i] = rsp_rdata[i];
               held_err[i]   = rsp_err[i];
               chk($sformatf("rsp_expected[%0d]", i), 32'(pending[i]), 32'h1);
               chk($sformatf("latency[%0d]", i), 32'(last_lat[i]), 32'(1 + wc(i)));
               chk($sformatf("rdata[%0d]", i), rsp_rdata[i], exp_rdata[i]);
               chk($sformatf("err[%0d]", i), 32'(rsp_err[i]), 32'(exp_err[i]));
               pending[i] = 1'b0;
            end else if (rsp_valid[i]) begin
               chk($sformatf("rdata_stable[%0d]", i), rsp_rdata[i], held_rdata[i]);
               chk($sformatf("err_stable[%0d]", i), 32'(rsp_err[i]), 32'(held_err[i]));
            end
            if (req_ready[i] && req_valid[i]) acc_cyc[i] = cyc + 1;
            prev_valid[i] = rsp_valid[i];
         end
      end
   end

   task automatic wait_ready(input int i);
      int n = 0;
      while (!req_ready[i] && n < 50) begin @(posedge clk); #1; n++; end
      if (!req_ready[i]) begin
         errs++; vec++;
         $display("FAIL wait_ready[%0d]: req_ready still %b after 50 cycles, required 1", i, req_ready[i]);
      end
   endtask

   task automatic drive_req(input int i, input logic [31:0] a, input logic we,
                            input logic [31:0] wd, input logic [3:0] be);
      req_valid[i] = 1'b1; req_addr[i] = a; req_we[i] = we; req_wdata[i] = wd; req_be[i] = be;
      @(posedge clk); #1;
      // Scramble the bus after acceptance: the responder must use only the captured values.
      req_valid[i] = 1'b0; req_addr[i] = $urandom; req_we[i] = 1'($urandom);
      req_wdata[i] = $urandom; req_be[i] = 4'($urandom);
   endtask

   task automatic txn(input int i, input logic [31:0] a, input logic we, input logic [31:0] wd,
                      input logic [3:0] be, input bit hold);
      int n = 0;
      logic [31:0] rd;
      logic er;
      wait_ready(i);
      mdl_txn(i, a, we, wd, be, rd, er);
      exp_rdata[i] = rd; exp_err[i] = er; pending[i] = 1'b1;
      drive_req(i, a, we, wd, be);
      while (!rsp_valid[i] && n < 40) begin @(posedge clk); #1; n++; end
      if (!rsp_valid[i]) begin
         errs++; vec++;
         $display("FAIL rsp_timeout[%0d]: rsp_valid still %b after 40 cycles, required 1", i, rsp_valid[i]);
         return;
      end
      if (hold) begin
         repeat (5) begin
            @(posedge clk); #1;
            chk("hold_req_ready", 32'(req_ready[i]), 32'h0);
            chk("hold_rsp_valid", 32'(rsp_valid[i]), 32'h1);
         end
         rsp_ready[i] = 1'b1;
      end
      @(posedge clk); #1;
      chk("post_hs_req_ready", 32'(req_ready[i]), 32'h1);
      chk("post_hs_rsp_valid", 32'(rsp_valid[i]), 32'h0);
   endtask

   task automatic chk_reset_outputs(input int i, input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready[i]), 32'h1);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid[i]), 32'h0);
      chk({tag, "_rsp_rdata"}, rsp_rdata[i], 32'h0);
      chk({tag, "_rsp_err"},   32'(rsp_err[i]), 32'h0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_addr[i] = 32'h0; req_we[i] = 1'b0;
         req_wdata[i] = 32'h0; req_be[i] = 4'h0; rsp_ready[i] = 1'b1; pending[i] = 1'b0;
         exp_rdata[i] = 32'h0; exp_err[i] = 1'b0; acc_cyc[i] = 0;
      end
      #12;
      for (int i = 0; i < 3; i++) chk_reset_outputs(i, "por");
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

      // Basic store then load.
      txn(0, 32'h1000, 1'b1, 32'hDEADBEEF, 4'hF, 0);
      chk("store_rdata_lit", last_rdata[0], 32'h0);
      chk("store_err_lit", 32'(last_err[0]), 32'h0);
      txn(0, 32'h1000, 1'b0, 32'h0, 4'h0, 0);
      chk("load_1000_lit", last_rdata[0], 32'hDEADBEEF);
      chk("lat_w1_lit", 32'(last_lat[0]), 32'd2);

      // Byte-enable merge, and be=0 store as no-op.
      txn(0, 32'h1004, 1'b1, 32'h11223344, 4'hF, 0);
      txn(0, 32'h1004, 1'b1, 32'hAABBCCDD, 4'b0101, 0);
      txn(0, 32'h1004, 1'b0, 32'h0, 4'hF, 0);
      chk("be_merge_lit", last_rdata[0], 32'h11BB33DD);
      txn(0, 32'h1004, 1'b1, 32'hFFFFFFFF, 4'b0000, 0);
      txn(0, 32'h1004, 1'b0, 32'h0, 4'h0, 0);
      chk("be_zero_lit", last_rdata[0], 32'h11BB33DD);

      // Error cases: below base, one past the end, misaligned.
      txn(0, 32'h0FFC, 1'b0, 32'h0, 4'h0, 0);
      chk("err_below_lit", {last_rdata[0][30:0], last_err[0]}, 32'h1);
      txn(0, BASE + 4 * DEPTH, 1'b0, 32'h0, 4'h0, 0);
      chk("err_past_end_lit", {last_rdata[0][30:0], last_err[0]}, 32'h1);
      txn(0, 32'h1002, 1'b0, 32'h0, 4'h0, 0);
      chk("err_misalign_lit", {last_rdata[0][30:0], last_err[0]}, 32'h1);
      txn(0, 32'h1001, 1'b1, 32'h0, 4'hF, 0);
      txn(0, 32'h0FFC, 1'b1, 32'h0, 4'hF, 0);
      txn(0, BASE + 4 * DEPTH, 1'b1, 32'h0, 4'hF, 0);
      txn(0, 32'h1000, 1'b0, 32'h0, 4'h0, 0);
      chk("after_err_lit", last_rdata[0], 32'hDEADBEEF);

      // Last word in range.
      txn(0, BASE + 4 * (DEPTH - 1), 1'b1, 32'h5A5AA5A5, 4'hF, 0);
      txn(0, BASE + 4 * (DEPTH - 1), 1'b0, 32'h0, 4'h0, 0);
      chk("last_word_lit", last_rdata[0], 32'h5A5AA5A5);
      txn(0, 32'h1000, 1'b0, 32'h0, 4'h0, 0);
      chk("no_alias_lit", last_rdata[0], 32'hDEADBEEF);

      // Response held while rsp_ready is low.
      rsp_ready[0] = 1'b0;
      txn(0, 32'h1004, 1'b0, 32'h0, 4'h0, 1);
      chk("hold_rdata_lit", last_rdata[0], 32'h11BB33DD);

      // Reset during WAIT drops the store.
      txn(0, 32'h1008, 1'b1, 32'h01020304, 4'hF, 0);
      txn(0, 32'h1008, 1'b0, 32'h0, 4'h0, 0);
      wait_ready(0);
      drive_req(0, 32'h1008, 1'b1, 32'hCAFEF00D, 4'hF);
      #2 rst_n[0] = 1'b0;
      #1 chk_reset_outputs(0, "midrst");
      #10 rst_n[0] = 1'b1;
      txn(0, 32'h1008, 1'b0, 32'h0, 4'h0, 0);
      chk("midrst_prior_lit", last_rdata[0], 32'h01020304);

      // Wait-state extremes.
      txn(1, 32'h1000, 1'b1, 32'hDEADBEEF, 4'hF, 0);
      txn(1, 32'h1000, 1'b0, 32'h0, 4'h0, 0);
      chk("w0_load_lit", last_rdata[1], 32'hDEADBEEF);
      chk("w0_lat_lit", 32'(last_lat[1]), 32'd1);
      txn(2, 32'h1000, 1'b1, 32'hDEADBEEF, 4'hF, 0);
      txn(2, 32'h1000, 1'b0, 32'h0, 4'h0, 0);
      chk("w15_load_lit", last_rdata[2], 32'hDEADBEEF);
      chk("w15_lat_lit", 32'(last_lat[2]), 32'd16);

      repeat (3) @(posedge clk);
      for (int i = 0; i < 3; i++) chk($sformatf("no_pending[%0d]", i), 32'(pending[i]), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
